// File: rtl/packet_sender.sv
// packet_sender: reads a burst of GLB words and sends each as a {row_tag, col_tag, data} packet.
// Defining PACKET_SENDER_STALL_CNT_EN adds the stall_cycles output and its counter.
module packet_sender #(
  parameter int BITWIDTH        = 16,
  parameter int TAG_LENGTH      = 4,
  parameter int GLB_ADDR_LENGTH = 3,
  parameter int PACKET_LENGTH   = 2*TAG_LENGTH+BITWIDTH
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       start,
  input  logic [GLB_ADDR_LENGTH-1:0] base_addr,
  input  logic [GLB_ADDR_LENGTH:0]   word_count,
  input  logic [TAG_LENGTH-1:0]      row_max,
  input  logic [TAG_LENGTH-1:0]      col_max,
  output logic [GLB_ADDR_LENGTH-1:0] glb_addr,
  output logic                       glb_cs,
  output logic                       glb_oe,
  input  logic [BITWIDTH-1:0]        glb_rdata,
  output logic [PACKET_LENGTH-1:0]   data_packet,
  output logic                       gin_enable,
  input  logic                       gin_ready,
  output logic                       busy,
  output logic                       done,
`ifdef PACKET_SENDER_STALL_CNT_EN
  output logic [15:0]                stall_cycles,
`endif
  output logic [2:0]                 state_dbg
);

  // Handshake: a packet moves on a rising edge where gin_enable and gin_ready are both 1;
  // until then gin_enable stays high and data_packet does not change.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [GLB_ADDR_LENGTH-1:0] ADDR_ONE = 1;
  localparam logic [GLB_ADDR_LENGTH:0]   CNT_ONE  = 1;
  localparam logic [TAG_LENGTH-1:0]      TAG_ONE  = 1;

  state_t                     state_q, state_d;
  logic [GLB_ADDR_LENGTH-1:0] addr_q;
  logic [GLB_ADDR_LENGTH:0]   count_q;
  logic [TAG_LENGTH-1:0]      row_q, col_q, row_max_q, col_max_q;
  logic [BITWIDTH-1:0]        data_q;
  logic                       xfer;

  assign xfer = (state_q == S_SEND) && gin_ready;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    glb_cs     = 1'b0;
    glb_oe     = 1'b0;
    gin_enable = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = (word_count == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        glb_cs  = 1'b1;
        glb_oe  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: state_d = S_SEND;
      S_SEND: begin
        gin_enable = 1'b1;
        if (gin_ready) state_d = (count_q == CNT_ONE) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Burst parameters are latched at start so later input changes cannot disturb the burst.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      addr_q    <= '0;
      count_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      row_max_q <= '0;
      col_max_q <= '0;
      data_q    <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        addr_q    <= base_addr;
        count_q   <= word_count;
        row_max_q <= row_max;
        col_max_q <= col_max;
        row_q     <= '0;
        col_q     <= '0;
      end
      if (state_q == S_WAIT) data_q <= glb_rdata;
      if (xfer) begin
        count_q <= count_q - CNT_ONE;
        addr_q  <= addr_q + ADDR_ONE;
        if (col_q == col_max_q) begin
          col_q <= '0;
          row_q <= (row_q == row_max_q) ? '0 : row_q + TAG_ONE;
        end else begin
          col_q <= col_q + TAG_ONE;
        end
      end
    end
  end

`ifdef PACKET_SENDER_STALL_CNT_EN
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      stall_cycles <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_cycles <= '0;
    end else if (state_q == S_SEND && !gin_ready && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

  assign glb_addr    = addr_q;
  assign data_packet = {row_q, col_q, data_q};
  assign state_dbg   = state_q;

endmodule
